// File: rtl/csr_cmd_encoder.sv
// csr_cmd_encoder: turns host CSR requests into command/data words for a SPI link and reports completion
module csr_cmd_encoder #(
  parameter logic [3:0] WRITE_COMMAND = 4'h1,
  parameter logic [3:0] READ_COMMAND  = 4'h2,
  parameter int         GAP_CYCLES    = 2,
  parameter int         TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [11:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] tx_data,
  input  logic        rx_valid,
  input  logic [15:0] rx_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_timeout
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SEND_CMD  = 3'd1;
  localparam logic [2:0] GAP       = 3'd2;
  localparam logic [2:0] SEND_DATA = 3'd3;
  localparam logic [2:0] WAIT_RSP  = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  logic [2:0] state;
  logic wr;
  logic data_sent;
  logic [15:0] wdata;
  logic [3:0] gap_cnt;
  logic [15:0] wait_cnt;
  assign req_ready = (state == IDLE) && !rst;
  assign tx_valid  = (state == SEND_CMD) || (state == SEND_DATA);
  assign rsp_valid = (state == DONE);
  // tx_data is only reloaded on the edge where tx_valid rises, so it holds while idle or stalled
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      wr          <= 1'b0;
      data_sent   <= 1'b0;
      wdata       <= '0;
      gap_cnt     <= '0;
      wait_cnt    <= '0;
      tx_data     <= '0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
    end else
      case (state)
        IDLE: if (req_valid) begin
          wr        <= req_write;
          wdata     <= req_wdata;
          data_sent <= 1'b0;
          tx_data   <= {req_write ? WRITE_COMMAND : READ_COMMAND, req_addr};
          state     <= SEND_CMD;
        end
        SEND_CMD: if (tx_ready) begin
          gap_cnt <= '0;
          state   <= GAP;
        end
        GAP: if (gap_cnt == GAP_LAST) begin
          if (data_sent) begin
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            state       <= DONE;
          end else if (wr) begin
            tx_data <= wdata;
            state   <= SEND_DATA;
          end else begin
            wait_cnt <= '0;
            state    <= WAIT_RSP;
          end
        end else gap_cnt <= gap_cnt + 4'd1;
        SEND_DATA: if (tx_ready) begin
          gap_cnt   <= '0;
          data_sent <= 1'b1;
          state     <= GAP;
        end
        WAIT_RSP: if (rx_valid) begin
          rsp_rdata   <= rx_data;
          rsp_timeout <= 1'b0;
          state       <= DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          rsp_rdata   <= '0;
          rsp_timeout <= 1'b1;
          state       <= DONE;
        end else wait_cnt <= wait_cnt + 16'd1;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule
